// File: rtl/cpu_mem_pkg.sv
// Shared CPU/memory definitions: responder FSM states, port-select encoding
// and default data width.
package cpu_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CPU_ADDR_W = 16;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_sel_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus: instruction-fetch port, data port and stall.
// Handshake: a request (i_re, or d_re/d_we) is held by the CPU until the
// matching one-cycle rdy pulse; the responder samples requests only while idle.
interface mem_responder_if
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                  i_re;
  logic [CPU_ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_rdy;
  logic                  d_re;
  logic                  d_we;
  logic [CPU_ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_rdy;
  logic                  stall;

  modport master (
    output i_re, i_addr, d_re, d_we, d_addr, d_wdata,
    input  i_rdata, i_rdy, d_rdata, d_rdy, stall
  );

  modport slave (
    input  i_re, i_addr, d_re, d_we, d_addr, d_wdata,
    output i_rdata, i_rdy, d_rdata, d_rdy, stall
  );
endinterface

// File: rtl/mem_array.sv
// Unified word-addressed storage: synchronous write, registered read.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the CPU's fetch and load/store ports.
// Optional MEM_RESP_STATS_EN adds a saturating stall_cycles counter.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_responder_if.slave bus,
  output mem_state_e dbg_state
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

  mem_state_e           state, state_nxt;
  logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
  port_sel_e            req_port;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [DATA_W-1:0]    i_hold, d_hold, arr_rdata;

  logic              d_req, accept, acc_we;
  port_sel_e         acc_port;
  logic [ADDR_W-1:0] acc_addr, rd_addr;
  logic              rd_we, arr_re, arr_we;
  logic              i_rdy, d_rdy, stall;
  logic              unused_hi_addr;

  // D-port wins arbitration; d_re together with d_we is a store.
  assign d_req    = bus.d_re | bus.d_we;
  assign accept   = (state == IDLE) && (d_req || bus.i_re);
  assign acc_port = d_req ? PORT_D : PORT_I;
  assign acc_addr = d_req ? bus.d_addr[ADDR_W-1:0] : bus.i_addr[ADDR_W-1:0];
  assign acc_we   = d_req & bus.d_we;
  assign unused_hi_addr = ^{bus.i_addr[CPU_ADDR_W-1:ADDR_W], bus.d_addr[CPU_ADDR_W-1:ADDR_W]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = LAT_LOAD;
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == LAT_CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The array read fires on the edge entering RESP; with LATENCY=1 that edge
  // is the acceptance edge, so the address comes straight from the inputs.
  assign rd_addr = (state == IDLE) ? acc_addr : req_addr;
  assign rd_we   = (state == IDLE) ? acc_we : req_we;
  assign arr_re  = (state != RESP) && (state_nxt == RESP) && !rd_we && !rst;
  assign arr_we  = (state == RESP) && req_we && !rst;

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(req_addr),
    .wdata(req_wdata),
    .re   (arr_re),
    .raddr(rd_addr),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_port  <= PORT_I;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      i_hold    <= '0;
      d_hold    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_port  <= acc_port;
        req_we    <= acc_we;
        req_addr  <= acc_addr;
        req_wdata <= bus.d_wdata;
      end
      if (i_rdy) i_hold <= arr_rdata;
      if (d_rdy && !req_we) d_hold <= arr_rdata;
    end
  end

  assign i_rdy = (state == RESP) && (req_port == PORT_I);
  assign d_rdy = (state == RESP) && (req_port == PORT_D);
  assign stall = (bus.i_re & ~i_rdy) | (d_req & ~d_rdy);

  assign bus.i_rdy   = i_rdy;
  assign bus.d_rdy   = d_rdy;
  assign bus.i_rdata = i_rdy ? arr_rdata : i_hold;
  assign bus.d_rdata = (d_rdy && !req_we) ? arr_rdata : d_hold;
  assign bus.stall   = stall;
  assign dbg_state   = state;

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the responder.
module tb_mem_responder;
  import cpu_mem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16)) bus ();
  mem_responder_if #(.DATA_W(16)) bus1 ();
  mem_state_e dbg_state, dbg_state1;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] stall_cycles, stall_cycles1;
`endif

  mem_responder #(.DATA_W(16), .ADDR_W(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
`ifdef MEM_RESP_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  mem_responder #(.DATA_W(16), .ADDR_W(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg_state1)
`ifdef MEM_RESP_STATS_EN
    , .stall_cycles(stall_cycles1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic model_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  logic [15:0] mmem [int];
  logic        m_busy = 1'b0;
  int          m_left;
  logic        m_port_d, m_we;
  int          m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_i_held, m_d_held;
  logic        m_i_known = 1'b0, m_d_known = 1'b0;

  always @(negedge clk) begin
    logic e_ir, e_dr, e_st, e_ik, e_dk;
    logic [15:0] e_id, e_dd;
    e_ir = m_busy && (m_left == 0) && !m_port_d;
    e_dr = m_busy && (m_left == 0) && m_port_d;
    e_id = m_i_held; e_ik = m_i_known;
    e_dd = m_d_held; e_dk = m_d_known;
    if (e_ir) begin
      e_ik = mmem.exists(m_addr);
      e_id = e_ik ? mmem[m_addr] : 16'h0;
    end
    if (e_dr && !m_we) begin
      e_dk = mmem.exists(m_addr);
      e_dd = e_dk ? mmem[m_addr] : 16'h0;
    end
    e_st = (bus.i_re && !e_ir) || ((bus.d_re || bus.d_we) && !e_dr);
    if (model_en) begin
      chk("m_i_rdy", 32'(bus.i_rdy), 32'(e_ir));
      chk("m_d_rdy", 32'(bus.d_rdy), 32'(e_dr));
      chk("m_stall", 32'(bus.stall), 32'(e_st));
      if (e_ik) chk("m_i_rdata", 32'(bus.i_rdata), 32'(e_id));
      if (e_dk) chk("m_d_rdata", 32'(bus.d_rdata), 32'(e_dd));
    end
    m_i_held = e_id; m_i_known = e_ik;
    m_d_held = e_dd; m_d_known = e_dk;
    if (rst) begin
      m_busy = 1'b0;
      m_i_held = 16'h0; m_d_held = 16'h0;
      m_i_known = 1'b1; m_d_known = 1'b1;
    end else if (m_busy) begin
      if (m_left == 0) begin
        if (m_we) mmem[m_addr] = m_wdata;
        m_busy = 1'b0;
      end else begin
        m_left--;
      end
    end else if (bus.d_re || bus.d_we) begin
      m_busy = 1'b1; m_port_d = 1'b1; m_we = bus.d_we;
      m_addr = int'(bus.d_addr[11:0]); m_wdata = bus.d_wdata; m_left = LAT - 1;
    end else if (bus.i_re) begin
      m_busy = 1'b1; m_port_d = 1'b0; m_we = 1'b0;
      m_addr = int'(bus.i_addr[11:0]); m_left = LAT - 1;
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    bus.i_re = 1'b0; bus.i_addr = '0;
    bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_d(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd);
    logic got;
    got = 1'b0;
    rd = '0;
    bus.d_we = we; bus.d_re = !we; bus.d_addr = a; bus.d_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.d_rdy) begin
        rd = bus.d_rdata;
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("d_rdy_timeout", 32'(got), 32'd1);
    tick();
    bus.d_we = 1'b0; bus.d_re = 1'b0;
  endtask

  logic [15:0] rd_v;

  initial begin
    clear_inputs();
    bus1.i_re = 1'b0; bus1.i_addr = '0;
    bus1.d_re = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    rst = 1'b1;
    tick(); tick();

    // Test 1: store then load after reset
    rst = 1'b0; model_en = 1'b1;
    bus.d_we = 1'b1; bus.d_addr = 16'h0005; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("rst_d_rdy", 32'(bus.d_rdy), 32'd0);
    chk("rst_i_rdy", 32'(bus.i_rdy), 32'd0);
    chk("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
    chk("rst_i_rdata", 32'(bus.i_rdata), 32'd0);
    chk("t1_stall_c0", 32'(bus.stall), 32'd1);
    tick(); @(negedge clk);
    chk("t1_stall_c1", 32'(bus.stall), 32'd1);
    chk("t1_d_rdy_c1", 32'(bus.d_rdy), 32'd0);
    tick(); @(negedge clk);
    chk("t1_d_rdy_c2", 32'(bus.d_rdy), 32'd1);
    tick();
    bus.d_we = 1'b0; bus.d_re = 1'b1;
    @(negedge clk);
    chk("t1_d_rdy_c3", 32'(bus.d_rdy), 32'd0);
    tick(); tick(); @(negedge clk);
    chk("t1_d_rdy_c5", 32'(bus.d_rdy), 32'd1);
    chk("t1_d_rdata_c5", 32'(bus.d_rdata), 32'hBEEF);
    tick(); clear_inputs();

    // Memory init for later scenarios and random traffic
    for (int a = 0; a < 16; a++) do_d(1'b1, 16'(a), 16'($urandom_range(0, 65535)), rd_v);
    do_d(1'b1, 16'h0010, 16'h1010, rd_v);
    do_d(1'b1, 16'h0020, 16'h2020, rd_v);
    do_d(1'b1, 16'h0030, 16'h3030, rd_v);
    do_d(1'b1, 16'h0040, 16'h4040, rd_v);

    // Test 2: simultaneous I and D requests, D wins
    bus.i_re = 1'b1; bus.i_addr = 16'h0010; bus.d_re = 1'b1; bus.d_addr = 16'h0020;
    @(negedge clk);
    chk("t2_stall_n", 32'(bus.stall), 32'd1);
    tick(); tick(); @(negedge clk);
    chk("t2_d_rdy_n2", 32'(bus.d_rdy), 32'd1);
    chk("t2_i_rdy_n2", 32'(bus.i_rdy), 32'd0);
    chk("t2_d_rdata", 32'(bus.d_rdata), 32'h2020);
    tick(); bus.d_re = 1'b0;
    @(negedge clk);
    chk("t2_i_stall_n3", 32'(bus.stall), 32'd1);
    tick(); tick(); @(negedge clk);
    chk("t2_i_rdy_n5", 32'(bus.i_rdy), 32'd1);
    chk("t2_i_rdata", 32'(bus.i_rdata), 32'h1010);
    tick(); clear_inputs();

    // Test 3: fetch address redirected while busy
    bus.i_re = 1'b1; bus.i_addr = 16'h0030;
    tick(); bus.i_addr = 16'h0040;
    tick(); @(negedge clk);
    chk("t3_i_rdy_a", 32'(bus.i_rdy), 32'd1);
    chk("t3_i_rdata_a", 32'(bus.i_rdata), 32'h3030);
    tick(); tick(); tick(); @(negedge clk);
    chk("t3_i_rdy_b", 32'(bus.i_rdy), 32'd1);
    chk("t3_i_rdata_b", 32'(bus.i_rdata), 32'h4040);
    tick(); clear_inputs();

    // Test 4: reset during a pending store
    do_d(1'b1, 16'h0007, 16'h1111, rd_v);
    bus.d_we = 1'b1; bus.d_addr = 16'h0007; bus.d_wdata = 16'h2222;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t4_d_rdy_rst", 32'(bus.d_rdy), 32'd0);
    tick(); rst = 1'b0; clear_inputs();
    @(negedge clk);
    chk("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("t4_d_rdy_after", 32'(bus.d_rdy), 32'd0);
    tick();
    do_d(1'b0, 16'h0007, 16'h0, rd_v);
    chk("t4_old_value", 32'(rd_v), 32'h1111);

    // Test 5: LATENCY=1 instance, wrap store and back-to-back loads
    bus1.d_we = 1'b1; bus1.d_addr = 16'h1007; bus1.d_wdata = 16'hA5A5;
    @(negedge clk);
    chk("t5_rdy_a0", 32'(bus1.d_rdy), 32'd0);
    tick(); @(negedge clk);
    chk("t5_rdy_a1", 32'(bus1.d_rdy), 32'd1);
    tick(); bus1.d_we = 1'b0; bus1.d_re = 1'b1; bus1.d_addr = 16'h0007;
    @(negedge clk);
    chk("t5_rdy_n", 32'(bus1.d_rdy), 32'd0);
    tick(); @(negedge clk);
    chk("t5_rdy_n1", 32'(bus1.d_rdy), 32'd1);
    chk("t5_rdata_n1", 32'(bus1.d_rdata), 32'hA5A5);
    tick(); @(negedge clk);
    chk("t5_rdy_n2", 32'(bus1.d_rdy), 32'd0);
    tick(); @(negedge clk);
    chk("t5_rdy_n3", 32'(bus1.d_rdy), 32'd1);
    chk("t5_rdata_n3", 32'(bus1.d_rdata), 32'hA5A5);
    tick(); bus1.d_re = 1'b0;

`ifdef MEM_RESP_STATS_EN
    // Test 6: stall counter, then saturation
    rst = 1'b1; tick(); rst = 1'b0;
    bus.d_re = 1'b1; bus.d_addr = 16'h0005;
    for (int k = 0; k < 9; k++) tick();
    bus.d_re = 1'b0;
    @(negedge clk);
    chk("t6_stall_cycles", stall_cycles, 32'd6);
    tick();
    force dut.stall_cycles = 32'hFFFF_FFFE;
    #2;
    release dut.stall_cycles;
    bus.d_re = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    bus.d_re = 1'b0;
    @(negedge clk);
    chk("t6_saturate", stall_cycles, 32'hFFFF_FFFF);
    tick();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      bus.i_re    = 1'($urandom_range(0, 1));
      bus.i_addr  = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      bus.d_re    = ($urandom_range(0, 2) == 0);
      bus.d_we    = ($urandom_range(0, 3) == 0);
      bus.d_addr  = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      bus.d_wdata = 16'($urandom_range(0, 65535));
      rst         = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    for (int k = 0; k < 5; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
